// File: rtl/dmem_access_ctrl.sv
// Data RAM access controller: CPU/DMA arbitration, byte-lane formatting.
// Optional: DMEM_UNSIGNED_LOAD_EN adds cpu_unsigned for LHU/LBU loads.
module dmem_access_ctrl #(
   parameter int DEPTH        = 64,
   parameter int AW           = 6,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [1:0]    cpu_type,
   input  logic [31:0]   cpu_addr,
   input  logic [31:0]   cpu_wdata,
`ifdef DMEM_UNSIGNED_LOAD_EN
   input  logic          cpu_unsigned,
`endif
   output logic          cpu_ack,
   output logic [31:0]   cpu_rdata,
   output logic          cpu_err,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [31:0]   dma_wdata,
   output logic          dma_ack,
   output logic [31:0]   dma_rdata,
   output logic          ram_en,
   output logic          ram_we,
   output logic [3:0]    ram_be,
   output logic [AW-1:0] ram_addr,
   output logic [31:0]   ram_wdata,
   input  logic [31:0]   ram_rdata
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t        state, next_state;
   logic [SW-1:0] starve_cnt;
   logic          dma_win, cpu_win, cpu_bad, uns_in;
   logic          sel_dma, sel_err, sel_we, sel_uns;
   logic [1:0]    sel_type, sel_lane;
   logic [3:0]    be_fmt;
   logic [31:0]   wd_fmt, ld_fmt;
   logic [15:0]   hsel;
   logic [7:0]    bsel;

`ifdef DMEM_UNSIGNED_LOAD_EN
   assign uns_in = cpu_unsigned;
`else
   assign uns_in = 1'b0;
`endif

   assign dma_win = dma_req &&
                    (!cpu_req || starve_cnt == SW'(STARVE_LIMIT));
   assign cpu_win = cpu_req && !dma_win;

   // Error decode: reserved type, misalignment, or beyond the RAM
   always_comb begin
      cpu_bad = 1'b0;
      if ({2'b00, cpu_addr[31:2]} >= 32'(DEPTH)) cpu_bad = 1'b1;
      unique case (cpu_type)
         2'b00:   if (cpu_addr[1:0] != 2'b00) cpu_bad = 1'b1;
         2'b01:   if (cpu_addr[0]) cpu_bad = 1'b1;
         2'b10:   ;
         default: cpu_bad = 1'b1;
      endcase
   end

   // Store lane enables and replicated write data
   always_comb begin
      be_fmt = 4'b1111;
      wd_fmt = cpu_wdata;
      unique case (cpu_type)
         2'b01: begin
            be_fmt = 4'b0011 << {cpu_addr[1], 1'b0};
            wd_fmt = {2{cpu_wdata[15:0]}};
         end
         2'b10: begin
            be_fmt = 4'b0001 << cpu_addr[1:0];
            wd_fmt = {4{cpu_wdata[7:0]}};
         end
         default: ;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (dma_win)      next_state = ACCESS;
            else if (cpu_win) next_state = cpu_bad ? RESP : ACCESS;
         end
         ACCESS:  next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Starvation counter: counts DMA losses, cleared when DMA is granted
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (state == IDLE) begin
         if (dma_win)
            starve_cnt <= '0;
         else if (cpu_win && dma_req &&
                  starve_cnt != SW'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // Latch the granted request for the response phase
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sel_dma  <= 1'b0;
         sel_err  <= 1'b0;
         sel_we   <= 1'b0;
         sel_uns  <= 1'b0;
         sel_type <= 2'b00;
         sel_lane <= 2'b00;
      end else if (state == IDLE && (dma_win || cpu_win)) begin
         sel_dma  <= dma_win;
         sel_err  <= cpu_win && cpu_bad;
         sel_we   <= dma_win ? dma_we : cpu_we;
         sel_uns  <= !dma_win && uns_in;
         sel_type <= dma_win ? 2'b00 : cpu_type;
         sel_lane <= dma_win ? 2'b00 : cpu_addr[1:0];
      end
   end

   // Registered RAM strobe: one cycle, only for a valid granted access
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         ram_be    <= 4'b0000;
         ram_addr  <= '0;
         ram_wdata <= '0;
      end else if (state == IDLE && dma_win) begin
         ram_en    <= 1'b1;
         ram_we    <= dma_we;
         ram_be    <= 4'b1111;
         ram_addr  <= dma_addr;
         ram_wdata <= dma_we ? dma_wdata : 32'h0;
      end else if (state == IDLE && cpu_win && !cpu_bad) begin
         ram_en    <= 1'b1;
         ram_we    <= cpu_we;
         ram_be    <= be_fmt;
         ram_addr  <= cpu_addr[AW+1:2];
         ram_wdata <= cpu_we ? wd_fmt : 32'h0;
      end else begin
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         ram_be    <= 4'b0000;
         ram_addr  <= '0;
         ram_wdata <= '0;
      end
   end

   // Load lane select with sign or zero extension
   always_comb begin
      hsel   = sel_lane[1] ? ram_rdata[31:16] : ram_rdata[15:0];
      bsel   = ram_rdata[{sel_lane, 3'b000} +: 8];
      ld_fmt = ram_rdata;
      unique case (sel_type)
         2'b01:   ld_fmt = {{16{hsel[15] & ~sel_uns}}, hsel};
         2'b10:   ld_fmt = {{24{bsel[7] & ~sel_uns}}, bsel};
         default: ld_fmt = ram_rdata;
      endcase
   end

   // Response outputs: only non-zero in RESP for the granted side
   always_comb begin
      cpu_ack   = 1'b0;
      cpu_err   = 1'b0;
      cpu_rdata = 32'h0;
      dma_ack   = 1'b0;
      dma_rdata = 32'h0;
      if (state == RESP) begin
         if (sel_dma) begin
            dma_ack   = 1'b1;
            dma_rdata = ram_rdata;
         end else begin
            cpu_ack = 1'b1;
            cpu_err = sel_err;
            if (!sel_err && !sel_we) cpu_rdata = ld_fmt;
         end
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl with a behavioural 1-cycle RAM.
// Build with DMEM_UNSIGNED_LOAD_EN to also cover LHU/LBU.
module tb_dmem_access_ctrl;

   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cpu_req, cpu_we;
   logic [1:0]    cpu_type;
   logic [31:0]   cpu_addr, cpu_wdata;
   logic          cpu_unsigned;
   logic          cpu_ack, cpu_err;
   logic [31:0]   cpu_rdata;
   logic          dma_req, dma_we;
   logic [AW-1:0] dma_addr;
   logic [31:0]   dma_wdata;
   logic          dma_ack;
   logic [31:0]   dma_rdata;
   logic          ram_en, ram_we;
   logic [3:0]    ram_be;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_wdata, ram_rdata;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      bit          dma;
      logic [31:0] rd;
      bit          err;
      int          cyc;
   } ack_t;

   typedef struct {
      bit          we;
      logic [5:0]  addr;
      logic [3:0]  be;
      logic [31:0] wd;
      bit          full;
   } ram_t;

   ack_t ack_q[$];
   ram_t ram_q[$];
   logic [31:0] mem [64];

   dmem_access_ctrl #(.DEPTH(64), .AW(AW), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_type(cpu_type),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
`ifdef DMEM_UNSIGNED_LOAD_EN
      .cpu_unsigned(cpu_unsigned),
`endif
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
      .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous single-port RAM, read-before-write
   always @(posedge clk) begin
      if (ram_en) begin
         ram_rdata <= mem[ram_addr];
         if (ram_we)
            for (int b = 0; b < 4; b++)
               if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
   end

   function automatic void chk(string nm, logic [127:0] a, logic [127:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at cyc %0d", nm, a, e, cyc);
      end
   endfunction

   // Monitor: pop and compare whenever the DUT acks or strobes the RAM
   always @(negedge clk) begin
      ack_t a;
      ram_t r;
      if (cpu_ack || dma_ack) begin
         if (ack_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack cpu=%b dma=%b cyc %0d",
                     cpu_ack, dma_ack, cyc);
         end else begin
            a = ack_q.pop_front();
            chk("ack_src", {cpu_ack, dma_ack}, a.dma ? 2'b01 : 2'b10);
            chk("rdata", a.dma ? dma_rdata : cpu_rdata, a.rd);
            if (!a.dma) chk("cpu_err", cpu_err, a.err);
            chk("ack_cycle", cyc, a.cyc);
         end
      end
      if (ram_en) begin
         if (ram_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ram_en addr=%h cyc %0d", ram_addr, cyc);
         end else begin
            r = ram_q.pop_front();
            chk("ram_we", ram_we, r.we);
            chk("ram_addr", ram_addr, r.addr);
            if (r.full) chk("ram_be", ram_be, r.be);
            if (r.we) chk("ram_wdata", ram_wdata, r.wd);
         end
      end
   end

   task automatic wait_ack(input bit dma, input string nm);
      bit got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         got = dma ? dma_ack : cpu_ack;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL timeout_%s actual=no_ack expected=ack", nm);
      end
   endtask

   task automatic cpu_op(input bit we, input logic [1:0] ty,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input bit uns, input logic [31:0] erd,
                         input bit eerr, input bit full,
                         input logic [3:0] ebe, input logic [31:0] ewd);
      ack_t a;
      ram_t r;
      @(posedge clk);
      #1;
      cpu_we = we;
      cpu_type = ty;
      cpu_addr = addr;
      cpu_wdata = wd;
      cpu_unsigned = uns;
      cpu_req = 1'b1;
      a = '{dma: 0, rd: erd, err: eerr, cyc: cyc + (eerr ? 1 : 2)};
      ack_q.push_back(a);
      if (!eerr) begin
         r = '{we: we, addr: addr[7:2], be: ebe, wd: ewd, full: full};
         ram_q.push_back(r);
      end
      wait_ack(0, "cpu");
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
   endtask

   task automatic dma_op(input bit we, input logic [5:0] addr,
                         input logic [31:0] wd, input logic [31:0] erd);
      ack_t a;
      ram_t r;
      @(posedge clk);
      #1;
      dma_we = we;
      dma_addr = addr;
      dma_wdata = wd;
      dma_req = 1'b1;
      a = '{dma: 1, rd: erd, err: 0, cyc: cyc + 2};
      ack_q.push_back(a);
      r = '{we: we, addr: addr, be: 4'hF, wd: wd, full: 1};
      ram_q.push_back(r);
      wait_ack(1, "dma");
      @(posedge clk);
      #1;
      dma_req = 1'b0;
   endtask

   function automatic logic [127:0] all_out();
      return {17'h0, cpu_ack, cpu_rdata, cpu_err, dma_ack, dma_rdata,
              ram_en, ram_we, ram_be, ram_addr, ram_wdata};
   endfunction

   initial begin
      ack_t a;
      ram_t r;
      int k, nc, nd;
      rst_n = 1'b0;
      cpu_req = 0; cpu_we = 0; cpu_type = 0; cpu_addr = 0;
      cpu_wdata = 0; cpu_unsigned = 0;
      dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", all_out(), 128'h0);
      rst_n = 1'b1;

      // word store/load
      cpu_op(1, 2'b00, 32'h10, 32'hDEADBEEF, 0, 0, 0, 1, 4'hF, 32'hDEADBEEF);
      cpu_op(0, 2'b00, 32'h10, 0, 0, 32'hDEADBEEF, 0, 1, 4'hF, 0);
      // sub-word loads, sign extension
      cpu_op(1, 2'b00, 32'h10, 32'h80FF0102, 0, 0, 0, 1, 4'hF, 32'h80FF0102);
      cpu_op(0, 2'b10, 32'h13, 0, 0, 32'hFFFFFF80, 0, 0, 0, 0);
      cpu_op(0, 2'b01, 32'h12, 0, 0, 32'hFFFF80FF, 0, 0, 0, 0);
      cpu_op(0, 2'b10, 32'h10, 0, 0, 32'h00000002, 0, 0, 0, 0);
      cpu_op(0, 2'b10, 32'h11, 0, 0, 32'h00000001, 0, 0, 0, 0);
      cpu_op(0, 2'b01, 32'h10, 0, 0, 32'h00000102, 0, 0, 0, 0);
`ifdef DMEM_UNSIGNED_LOAD_EN
      cpu_op(0, 2'b10, 32'h13, 0, 1, 32'h00000080, 0, 0, 0, 0);
      cpu_op(0, 2'b01, 32'h12, 0, 1, 32'h000080FF, 0, 0, 0, 0);
      cpu_op(0, 2'b00, 32'h10, 0, 1, 32'h80FF0102, 0, 1, 4'hF, 0);
`endif
      // sub-word stores
      cpu_op(1, 2'b00, 32'h20, 32'h0, 0, 0, 0, 1, 4'hF, 32'h0);
      cpu_op(1, 2'b10, 32'h21, 32'h123456AB, 0, 0, 0, 1, 4'b0010, 32'hABABABAB);
      cpu_op(1, 2'b01, 32'h22, 32'hFFFF1234, 0, 0, 0, 1, 4'b1100, 32'h12341234);
      cpu_op(0, 2'b00, 32'h20, 0, 0, 32'h1234AB00, 0, 1, 4'hF, 0);
      // errors: no RAM cycle, ack one cycle after the request
      cpu_op(0, 2'b00, 32'h02, 0, 0, 0, 1, 0, 0, 0);
      cpu_op(0, 2'b00, 32'h100, 0, 0, 0, 1, 0, 0, 0);
      cpu_op(0, 2'b01, 32'h01, 0, 0, 0, 1, 0, 0, 0);
      cpu_op(0, 2'b11, 32'h00, 0, 0, 0, 1, 0, 0, 0);
      cpu_op(1, 2'b00, 32'h13, 32'h55555555, 0, 0, 1, 0, 0, 0);
      // last word in range
      cpu_op(1, 2'b00, 32'hFC, 32'h11223344, 0, 0, 0, 1, 4'hF, 32'h11223344);
      cpu_op(0, 2'b00, 32'hFC, 0, 0, 32'h11223344, 0, 1, 4'hF, 0);
      // DMA path
      dma_op(1, 6'd5, 32'hCAFEF00D, 0);
      dma_op(0, 6'd5, 0, 32'hCAFEF00D);
      cpu_op(0, 2'b00, 32'h14, 0, 0, 32'hCAFEF00D, 0, 1, 4'hF, 0);

      // both held: CPU x4, DMA, then CPU again
      @(posedge clk);
      #1;
      cpu_we = 0; cpu_type = 2'b00; cpu_addr = 32'h10; cpu_unsigned = 0;
      dma_we = 0; dma_addr = 6'd5;
      cpu_req = 1; dma_req = 1;
      k = cyc;
      for (int i = 0; i < 6; i++) begin
         if (i == 4) begin
            a = '{dma: 1, rd: 32'hCAFEF00D, err: 0, cyc: k + 2 + 3 * i};
            r = '{we: 0, addr: 6'd5, be: 4'hF, wd: 0, full: 1};
         end else begin
            a = '{dma: 0, rd: 32'h80FF0102, err: 0, cyc: k + 2 + 3 * i};
            r = '{we: 0, addr: 6'd4, be: 4'hF, wd: 0, full: 1};
         end
         ack_q.push_back(a);
         ram_q.push_back(r);
      end
      nc = 0;
      nd = 0;
      for (int i = 0; i < 40 && (nc < 5 || nd < 1); i++) begin
         @(negedge clk);
         if (cpu_ack) nc++;
         if (dma_ack) nd++;
         @(posedge clk);
         #1;
         if (nd >= 1) dma_req = 0;
         if (nc >= 5) cpu_req = 0;
      end
      cpu_req = 0;
      dma_req = 0;
      chk("arb_ack_counts", {nc[7:0], nd[7:0]}, {8'd5, 8'd1});

      // reset while ACCESS: access dropped, never acked
      @(posedge clk);
      #1;
      cpu_we = 0; cpu_type = 2'b00; cpu_addr = 32'h10; cpu_req = 1;
      r = '{we: 0, addr: 6'd4, be: 4'hF, wd: 0, full: 1};
      ram_q.push_back(r);
      @(posedge clk);
      #1;
      chk("in_access_ram_en", ram_en, 1'b1);
      rst_n = 0;
      @(posedge clk);
      #1;
      chk("reset_in_access", all_out(), 128'h0);
      cpu_req = 0;
      @(posedge clk);
      #1;
      rst_n = 1;
      cpu_op(0, 2'b00, 32'h14, 0, 0, 32'hCAFEF00D, 0, 1, 4'hF, 0);

      repeat (4) @(posedge clk);
      chk("ack_q_drained", 128'(ack_q.size()), 128'h0);
      chk("ram_q_drained", 128'(ram_q.size()), 128'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
